topk_stream_sorter: RTL and testbench
=====================================

// Module: topk_stream_sorter
// PURPOSE
//   Streaming top-K insertion sorter. Keeps the DEPTH best {key,tag} entries seen in a batch (min or max
//   by SORT_OP), then drains them best-first over a valid/ready port. Parallel-compare register array with
//   one insert per cycle. Sits between the distance generator and the network LUT, replacing fixed-size sorters.
// PARAMETERS
//   DEPTH    8   number of entries retained (K), >=2
//   KEY_W    17  key (distance) width, unsigned
//   TAG_W    20  payload width (e.g. {pointa,pointb}), carried untouched
//   SORT_OP  0   0: keep smallest keys, drain ascending; 1: keep largest keys, drain descending
// PORTS
//   clk        in   1                   clock
//   rst        in   1                   synchronous reset, active-high
//   in_key     in   KEY_W               candidate key
//   in_tag     in   TAG_W               candidate payload
//   in_last    in   1                   marks final beat of batch
//   in_vld     in   1                   candidate valid
//   in_rdy     out  1                   sorter accepting (ACCEPT state)
//   out_key    out  KEY_W               head entry key
//   out_tag    out  TAG_W               head entry payload
//   out_last   out  1                   head is final entry of drain
//   out_vld    out  1                   head valid (DRAIN state)
//   out_rdy    in   1                   downstream accepts head
//   kept_cnt   out  $clog2(DEPTH+1)     valid entries currently held
// BEHAVIOUR
//   Reset (rst high at clk edge): all slot valid bits 0, state=ACCEPT, kept_cnt=0, out_vld=0, out_last=0;
//     in_rdy=1 from first cycle after reset. Key/tag storage not reset.
//   States: ACCEPT -> DRAIN on accepted beat with in_last; DRAIN -> ACCEPT on handshake with out_last.
//   in_rdy = (state==ACCEPT); out_vld = (state==DRAIN) && slot0 valid. Beat accepted when in_vld&&in_rdy.
//   Insert (ACCEPT, 1 beat/cycle, no stall): "better" = key < slot key (SORT_OP=0) or > (SORT_OP=1);
//     insertion index = first slot that is invalid or whose key is worse-than-not-equal... i.e. new entry goes
//     after all slots with key better-or-equal (stable: equal keys drain in arrival order).
//   Slots at/after index shift down one; slot DEPTH-1 drops off. If index==DEPTH (full, new not better than
//     worst) beat is discarded, array unchanged. kept_cnt = min(kept_cnt+1, DEPTH); saturates, never wraps.
//   Latency: accepted beat present in array and kept_cnt on next cycle; in_last beat is inserted (or
//     discarded) same as any beat, state=DRAIN next cycle, out_vld high that cycle (array never empty).
//   Drain: out_* driven from slot0 registers; on out_vld&&out_rdy slots shift up one, last slot invalidated,
//     kept_cnt decrements. out_last = kept_cnt==1. One entry per cycle with out_rdy held high.
//   Backpressure: while out_vld && !out_rdy, out_key/out_tag/out_last/out_vld held stable.
//   in_vld in DRAIN is ignored (in_rdy=0); out_rdy in ACCEPT ignored.
//   After final drain handshake: array empty, kept_cnt=0, state=ACCEPT next cycle; new batch independent.
//   Reset mid-batch or mid-drain: immediate return to reset values; partial contents discarded.
//   Arithmetic: unsigned key compares only; no arithmetic on tag.
// TESTING
//   T1 DEPTH=4,SORT_OP=0: keys 9,3,7,1,5,8(last) -> drain 1,3,5,7; out_last on 7; kept_cnt 4->0.
//   T2 DEPTH=4,SORT_OP=1: same stimulus -> drain 9,8,7,5 with matching tags.
//   T3 ties: key 4 tag A, key 4 tag B, key 2 tag C(last) -> drain C,A,B (stable order).
//   T4 short batch: keys 6,2(last) on DEPTH=4 -> drain 2,6, out_last on 6, kept_cnt peaks at 2.
//   T5 backpressure: out_rdy toggles 1,0,0,1 each cycle during drain -> outputs stable while low, no loss/dup;
//      in_vld pulsed in DRAIN -> ignored, in_rdy=0.
//   T6 rst asserted mid-drain after 2 of 4 outputs -> next cycle out_vld=0, in_rdy=1, kept_cnt=0;
//      following batch 5,1(last) drains exactly 1,5.

Source files
------------

// File: rtl/topk_stream_sorter_if.sv
// Candidate-in / sorted-out stream bundle for topk_stream_sorter.
//   in_key/in_tag/in_last/in_vld -> sorter, in_rdy <- sorter  (candidate beats)
//   out_key/out_tag/out_last/out_vld <- sorter, out_rdy -> sorter (drained entries)
// modport slave : sorter side. modport master: producer/consumer side.
interface topk_stream_sorter_if #(
    parameter int KEY_W = 17,
    parameter int TAG_W = 20
);
    logic [KEY_W-1:0] in_key;
    logic [TAG_W-1:0] in_tag;
    logic             in_last;
    logic             in_vld;
    logic             in_rdy;
    logic [KEY_W-1:0] out_key;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;
    logic             out_vld;
    logic             out_rdy;

    modport slave (
        input  in_key, in_tag, in_last, in_vld, out_rdy,
        output in_rdy, out_key, out_tag, out_last, out_vld
    );

    modport master (
        output in_key, in_tag, in_last, in_vld, out_rdy,
        input  in_rdy, out_key, out_tag, out_last, out_vld
    );
endinterface

// File: rtl/topk_stream_sorter.sv
// Streaming top-K insertion sorter. Keeps the DEPTH best {key,tag} entries of a
// batch (smallest keys when SORT_OP=0, largest when SORT_OP=1) in a sorted
// register array, one insert per cycle, then drains them best-first.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   s          stream bundle (slave): candidate input and sorted output
//   kept_cnt   number of valid entries currently held
module topk_stream_sorter #(
    parameter int DEPTH   = 8,
    parameter int KEY_W   = 17,
    parameter int TAG_W   = 20,
    parameter bit SORT_OP = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    topk_stream_sorter_if.slave        s,
    output logic [$clog2(DEPTH+1)-1:0] kept_cnt
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {ACCEPT, DRAIN} state_t;

    state_t                        state_q, state_d;
    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0][KEY_W-1:0]   key_q, key_d;
    logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    // stay[i]: slot i holds a key better than or equal to the candidate, so it
    // keeps its place. Because the array is sorted, stay is a prefix mask; the
    // candidate lands in the first non-staying slot (after equal keys -> stable).
    logic [DEPTH-1:0]              stay;
    logic                          acc_beat;
    logic                          pop;

    assign s.in_rdy   = (state_q == ACCEPT);
    assign s.out_vld  = (state_q == DRAIN) && vld_q[0];
    assign s.out_last = (state_q == DRAIN) && (cnt_q == CNT_W'(1));
    assign s.out_key  = key_q[0];
    assign s.out_tag  = tag_q[0];
    assign kept_cnt   = cnt_q;

    assign acc_beat = s.in_vld && (state_q == ACCEPT);
    assign pop      = s.out_vld && s.out_rdy;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (SORT_OP)
                stay[i] = vld_q[i] && (key_q[i] >= s.in_key);
            else
                stay[i] = vld_q[i] && (key_q[i] <= s.in_key);
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        key_d   = key_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        if (acc_beat) begin
            // Non-staying slots either take the candidate (first one) or the
            // entry above (the rest); when every slot stays the beat is dropped.
            if (!stay[0]) begin
                vld_d[0] = 1'b1;
                key_d[0] = s.in_key;
                tag_d[0] = s.in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (!stay[i]) begin
                    if (stay[i-1]) begin
                        vld_d[i] = 1'b1;
                        key_d[i] = s.in_key;
                        tag_d[i] = s.in_tag;
                    end else begin
                        vld_d[i] = vld_q[i-1];
                        key_d[i] = key_q[i-1];
                        tag_d[i] = tag_q[i-1];
                    end
                end
            end
            if (cnt_q != CNT_W'(DEPTH))
                cnt_d = cnt_q + CNT_W'(1);
            if (s.in_last)
                state_d = DRAIN;
        end else if (pop) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                vld_d[i] = vld_q[i+1];
                key_d[i] = key_q[i+1];
                tag_d[i] = tag_q[i+1];
            end
            vld_d[DEPTH-1] = 1'b0;
            cnt_d = cnt_q - CNT_W'(1);
            if (s.out_last)
                state_d = ACCEPT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            vld_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload storage is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        tag_q <= tag_d;
    end
endmodule

// File: tb/tb_topk_stream_sorter.sv
module tb_topk_stream_sorter;
    localparam int DEPTH = 4;
    localparam int KEY_W = 17;
    localparam int TAG_W = 20;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct {int key; int tag;} ent_t;
    typedef ent_t q_t[$];
    typedef int   iq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    topk_stream_sorter_if #(.KEY_W(KEY_W), .TAG_W(TAG_W)) if0 ();
    topk_stream_sorter_if #(.KEY_W(KEY_W), .TAG_W(TAG_W)) if1 ();
    logic [CW-1:0] kc0, kc1;

    topk_stream_sorter #(.DEPTH(DEPTH), .KEY_W(KEY_W), .TAG_W(TAG_W), .SORT_OP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .s(if0), .kept_cnt(kc0));
    topk_stream_sorter #(.DEPTH(DEPTH), .KEY_W(KEY_W), .TAG_W(TAG_W), .SORT_OP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .s(if1), .kept_cnt(kc1));

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 0;
    q_t  b0, d0, b1, d1;     // batch beats seen so far / expected drain order
    bit  acc0 = 1, acc1 = 1; // model: accepting
    iq_t lk0, lt0, lk1, lt1; // drained keys/tags observed from each DUT

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input iq_t a, input iq_t e);
        chk({name, ".len"}, a.size(), e.size());
        for (int i = 0; i < a.size() && i < e.size(); i++)
            chk($sformatf("%s[%0d]", name, i), a[i], e[i]);
    endtask

    // Best DEPTH entries of the whole batch by repeated selection; strict
    // comparison keeps the earliest arrival first among equal keys.
    function automatic q_t top_of(input q_t b, input bit op);
        q_t r = b;
        q_t res = {};
        int n = (b.size() < DEPTH) ? b.size() : DEPTH;
        for (int k = 0; k < n; k++) begin
            int j = 0;
            for (int i = 1; i < r.size(); i++)
                if (op ? (r[i].key > r[j].key) : (r[i].key < r[j].key)) j = i;
            res.push_back(r[j]);
            r.delete(j);
        end
        return res;
    endfunction

    task automatic step(input bit op, input logic r, input logic vld, input logic [KEY_W-1:0] key,
                        input logic [TAG_W-1:0] tag, input logic last, input logic rdy,
                        inout q_t b, inout q_t d, inout bit acc);
        ent_t e;
        if (r) begin
            b.delete(); d.delete(); acc = 1;
        end else if (acc && vld) begin
            e.key = int'(key); e.tag = int'(tag);
            b.push_back(e);
            if (last) begin
                d = top_of(b, op); b.delete(); acc = 0;
            end
        end else if (!acc && rdy && d.size() > 0) begin
            void'(d.pop_front());
            if (d.size() == 0) acc = 1;
        end
    endtask

    task automatic cmp(input string id, input logic rdy, input logic vld, input logic [KEY_W-1:0] key,
                       input logic [TAG_W-1:0] tag, input logic last, input logic [CW-1:0] kc,
                       input bit acc, input q_t b, input q_t d);
        int exp_cnt = acc ? ((b.size() < DEPTH) ? b.size() : DEPTH) : d.size();
        chk({id, ".in_rdy"}, rdy, acc);
        chk({id, ".kept_cnt"}, kc, exp_cnt);
        chk({id, ".out_vld"}, vld, !acc && d.size() > 0);
        if (!acc && d.size() > 0) begin
            chk({id, ".out_key"}, key, d[0].key);
            chk({id, ".out_tag"}, tag, d[0].tag);
            chk({id, ".out_last"}, last, d.size() == 1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        step(1'b0, rst, if0.in_vld, if0.in_key, if0.in_tag, if0.in_last, if0.out_rdy, b0, d0, acc0);
        step(1'b1, rst, if1.in_vld, if1.in_key, if1.in_tag, if1.in_last, if1.out_rdy, b1, d1, acc1);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("dut0", if0.in_rdy, if0.out_vld, if0.out_key, if0.out_tag, if0.out_last, kc0, acc0, b0, d0);
            cmp("dut1", if1.in_rdy, if1.out_vld, if1.out_key, if1.out_tag, if1.out_last, kc1, acc1, b1, d1);
            if (if0.out_vld && if0.out_rdy && !rst) begin
                lk0.push_back(int'(if0.out_key)); lt0.push_back(int'(if0.out_tag));
            end
            if (if1.out_vld && if1.out_rdy && !rst) begin
                lk1.push_back(int'(if1.out_key)); lt1.push_back(int'(if1.out_tag));
            end
        end
    end

    task automatic set_in(input bit v, input int k, input int t, input bit l);
        if0.in_vld = v; if0.in_key = KEY_W'(k); if0.in_tag = TAG_W'(t); if0.in_last = l;
        if1.in_vld = v; if1.in_key = KEY_W'(k); if1.in_tag = TAG_W'(t); if1.in_last = l;
    endtask

    task automatic set_rdy(input bit r);
        if0.out_rdy = r; if1.out_rdy = r;
    endtask

    task automatic beat(input int k, input int t, input bit l);
        set_in(1'b1, k, t, l);
        @(posedge clk); #1;
        set_in(1'b0, 0, 0, 1'b0);
    endtask

    // Drain until both models are back in accept; pat gives out_rdy per cycle
    // (LSB first, repeating); poke drives a stray beat on the second cycle.
    task automatic drain(input bit [3:0] pat, input bit poke);
        int cyc = 0;
        while (!(acc0 && acc1) && cyc < 64) begin
            set_rdy(pat[cyc % 4]);
            if (poke && cyc == 1) set_in(1'b1, 0, 'hDEAD, 1'b1);
            else                  set_in(1'b0, 0, 0, 1'b0);
            @(posedge clk); #1;
            cyc++;
        end
        set_rdy(1'b0);
        set_in(1'b0, 0, 0, 1'b0);
        chk("drain_done", acc0 && acc1, 1);
    endtask

    task automatic clr_logs();
        lk0.delete(); lt0.delete(); lk1.delete(); lt1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(1'b0, 0, 0, 1'b0);
        set_rdy(1'b0);
        rst = 1'b1;
        @(posedge clk);
        chk_en = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst.kept_cnt", kc0, 0);
        chk("rst.in_rdy", if0.in_rdy, 1);
        chk("rst.out_vld", if0.out_vld, 0);
        chk("rst.out_last", if0.out_last, 0);
        @(posedge clk); #1;

        // T1/T2: keys 9,3,7,1,5,8(last)
        clr_logs();
        beat(9, 'h100, 0); beat(3, 'h101, 0); beat(7, 'h102, 0);
        beat(1, 'h103, 0); beat(5, 'h104, 0); beat(8, 'h105, 1);
        drain(4'hF, 1'b0);
        chk_q("T1.keys", lk0, '{1, 3, 5, 7});
        chk_q("T1.tags", lt0, '{'h103, 'h101, 'h104, 'h102});
        chk_q("T2.keys", lk1, '{9, 8, 7, 5});
        chk_q("T2.tags", lt1, '{'h100, 'h105, 'h102, 'h104});

        // T3: equal keys drain in arrival order
        clr_logs();
        beat(4, 'hA, 0); beat(4, 'hB, 0); beat(2, 'hC, 1);
        drain(4'hF, 1'b0);
        chk_q("T3.tags0", lt0, '{'hC, 'hA, 'hB});
        chk_q("T3.tags1", lt1, '{'hA, 'hB, 'hC});

        // T4: short batch
        clr_logs();
        beat(6, 'h60, 0); beat(2, 'h20, 1);
        drain(4'hF, 1'b0);
        chk_q("T4.keys0", lk0, '{2, 6});
        chk_q("T4.keys1", lk1, '{6, 2});

        // T5: backpressure 1,0,0,1 plus a stray beat during drain
        clr_logs();
        beat(9, 'h100, 0); beat(3, 'h101, 0); beat(7, 'h102, 0);
        beat(1, 'h103, 0); beat(5, 'h104, 0); beat(8, 'h105, 1);
        drain(4'b1001, 1'b1);
        chk_q("T5.keys0", lk0, '{1, 3, 5, 7});
        chk_q("T5.keys1", lk1, '{9, 8, 7, 5});

        // T6: reset after two of four outputs
        clr_logs();
        beat(9, 'h1, 0); beat(3, 'h2, 0); beat(7, 'h3, 0); beat(1, 'h4, 1);
        set_rdy(1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        set_rdy(1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("T6.out_vld", if0.out_vld, 0);
        chk("T6.in_rdy", if0.in_rdy, 1);
        chk("T6.kept_cnt", kc0, 0);
        chk_q("T6.partial", lk0, '{1, 3});
        @(posedge clk); #1;
        clr_logs();
        beat(5, 'h50, 0); beat(1, 'h10, 1);
        drain(4'hF, 1'b0);
        chk_q("T6.keys0", lk0, '{1, 5});
        chk_q("T6.keys1", lk1, '{5, 1});

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
